hex_word_entry: RTL
===================

Name: hex_word_entry

Overview:
Parametrised front-panel word-entry block for the DES datapath. It assembles a WORD_W-bit word from DIGIT_W-bit switch digits, MSB digit first, committing one digit per load-button press. It presents the finished word to the encryption core over a valid/ready handshake. Successor to the fixed 64-bit nibble loader: adds generic widths, a clear control, full-word handshake and optional backspace.

Parameters:
DIGIT_W, 4, bits per entered digit (switch count).
WORD_W, 64, assembled word width; WORD_W % DIGIT_W must be 0 (elaboration error otherwise).
NDIG, WORD_W/DIGIT_W, derived digit count; not overridable.
CNT_W, $clog2(NDIG+1), derived width of the digit counter.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
digit_in  in  DIGIT_W  switch digit; digit_in[DIGIT_W-1] is the MSB.
load_btn  in  1  load push-button, active-low (0 = pressed), asynchronous to clk.
clear_btn  in  1  clear push-button, active-low, asynchronous to clk.
word_out  out  WORD_W  assembled word.
word_valid  out  1  word complete and offered to consumer.
word_ready  in  1  consumer accepts word_out.
n_entered  out  CNT_W  digits committed so far.
full  out  1  n_entered == NDIG.

Behaviour:
- Reset (rst=0, async): word_out=0, n_entered=0, word_valid=0, full=0, state=COLLECT, all sync flops set to 1 (released).
- Input sync: load_btn, clear_btn and digit_in each pass through 2 flops. A press is acted on 2 clk cycles after the asynchronous input changes. The digit committed is the synchronised digit_in in that same cycle.
- Press detection: one action per physical press. An action fires on the synced 1->0 edge. The detector re-arms only after a synced release (1).
- States: COLLECT, OFFER.
- COLLECT, load press, n_entered < NDIG:
  - Write the digit to word_out[WORD_W-1-n_entered*DIGIT_W -: DIGIT_W].
  - Increment n_entered.
  - If the new count == NDIG: go to OFFER and assert word_valid on the next cycle.
- OFFER:
  - word_valid=1, full=1. word_out is stable and must not change while valid.
  - Load presses are ignored and not queued.
  - Transfer occurs on word_valid && word_ready. The next cycle: word_valid=0, n_entered=0, state=COLLECT. word_out holds its old value until overwritten digit by digit.
- Clear press, any state:
  - Next cycle: n_entered=0, word_out=0, word_valid=0, state=COLLECT.
  - Clear beats transfer when both fall in the same cycle; no transfer is counted.
  - Clear beats a load press in the same cycle.
- word_ready while word_valid=0: ignored.
- Unwritten digit positions hold 0 (after reset or clear) or the previous word's bits (after a transfer).
- Counter never exceeds NDIG. No wrap-around.
- Reset mid-entry or mid-offer: immediate return to reset values; a pending offer is dropped.

Optional Feature:
Macro: HEX_WORD_ENTRY_BACKSPACE_EN.
- Defined:
  - Adds port bksp_btn (in, 1, active-low), synced and edge-detected like load_btn.
  - In COLLECT with n_entered > 0: decrement n_entered and zero the digit at the new index.
  - Ignored in OFFER and when n_entered == 0.
  - Priority: clear > backspace > load.
- Not defined: port absent; behaviour exactly as above.

Decomposition:
- Package des_io_pkg:
  - entry_state_t enum {COLLECT, OFFER}.
  - SYNC_STAGES = 2 constant.
  - Shared DIGIT_W/WORD_W defaults, reused by the key-entry instance.
- Sub-module btn_press_det: 2-flop synchroniser plus one-shot/re-arm detector, instantiated per button.

Test Plan:
- Reset, then 16 presses with digit_in = 0x0..0xF, word_ready=0 -> word_out=0x0123456789ABCDEF, word_valid=1, full=1, n_entered=16.
- From that state, 3 extra load presses -> word_out unchanged, n_entered=16. Then word_ready=1 for one cycle -> valid drops the next cycle, n_entered=0.
- Load held low for 50 cycles -> exactly one digit committed (n_entered=1).
- Enter 5 digits of 0xA, then clear press -> word_out=0, n_entered=0. Clear and word_ready in the same OFFER cycle -> no transfer, word_valid=0.
- rst pulsed low mid-entry at n_entered=7, off clock edge -> outputs zero immediately, without waiting for clk.
- (BACKSPACE_EN) Enter digits 0x1,0x2,0x3, backspace, then 0x9 -> top 12 bits=0x129, n_entered=3. Backspace at n_entered=0 -> no change.
- (Parameter sweep) DIGIT_W=8, WORD_W=32: 4 presses with 0xDE,0xAD,0xBE,0xEF -> word_out=0xDEADBEEF, word_valid=1.

Source files
------------

// File: rtl/des_io_pkg.sv
// des_io_pkg: shared entry-state type, synchroniser depth and default widths for DES front-panel I/O
package des_io_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int DIGIT_W_DEF = 4;
  localparam int WORD_W_DEF  = 64;
  typedef enum logic {COLLECT, OFFER} entry_state_t;
endpackage

// File: rtl/btn_press_det.sv
// btn_press_det: synchronises an active-low button (clk, rst async active-low, btn in, press out) and emits one pulse per press
module btn_press_det
  import des_io_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      prev <= sync[SYNC_STAGES-1];
    end
  // prev re-arms only once the synced level has returned high
  assign press = prev & ~sync[SYNC_STAGES-1];
endmodule

// File: rtl/hex_word_entry.sv
// hex_word_entry: assembles a WORD_W word MSB-digit-first from switch digits and offers it over valid/ready; ports clk, rst (async active-low), digit_in, load_btn, clear_btn, [bksp_btn when HEX_WORD_ENTRY_BACKSPACE_EN], word_out, word_valid, word_ready, n_entered, full
module hex_word_entry
  import des_io_pkg::*;
#(
  parameter  int DIGIT_W = DIGIT_W_DEF,
  parameter  int WORD_W  = WORD_W_DEF,
  localparam int NDIG    = WORD_W / DIGIT_W,
  localparam int CNT_W   = $clog2(NDIG + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               load_btn,
  input  logic               clear_btn,
`ifdef HEX_WORD_ENTRY_BACKSPACE_EN
  input  logic               bksp_btn,
`endif
  output logic [WORD_W-1:0]  word_out,
  output logic               word_valid,
  input  logic               word_ready,
  output logic [CNT_W-1:0]   n_entered,
  output logic               full
);
  if (WORD_W % DIGIT_W != 0) begin : g_bad_width
    $error("WORD_W must be a multiple of DIGIT_W");
  end
  entry_state_t state, nxt_state;
  logic [WORD_W-1:0] nxt_word;
  logic [CNT_W-1:0] nxt_cnt;
  logic [SYNC_STAGES-1:0][DIGIT_W-1:0] dsync;
  logic [DIGIT_W-1:0] dig;
  logic load_p, clr_p, bksp_p;
  btn_press_det u_load (.clk(clk), .rst(rst), .btn(load_btn), .press(load_p));
  btn_press_det u_clr (.clk(clk), .rst(rst), .btn(clear_btn), .press(clr_p));
`ifdef HEX_WORD_ENTRY_BACKSPACE_EN
  btn_press_det u_bksp (.clk(clk), .rst(rst), .btn(bksp_btn), .press(bksp_p));
`else
  assign bksp_p = 1'b0;
`endif
  // digit shares the button sync depth so it lines up with the detected press
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      dsync <= '1;
    else
      dsync <= {dsync[SYNC_STAGES-2:0], digit_in};
  assign dig = dsync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= COLLECT;
      word_out  <= '0;
      n_entered <= '0;
    end else begin
      state     <= nxt_state;
      word_out  <= nxt_word;
      n_entered <= nxt_cnt;
    end
  always_comb begin
    nxt_state = state;
    nxt_word  = word_out;
    nxt_cnt   = n_entered;
    if (clr_p) begin
      nxt_state = COLLECT;
      nxt_word  = '0;
      nxt_cnt   = '0;
    end else if (state == OFFER) begin
      if (word_ready) begin
        nxt_state = COLLECT;
        nxt_cnt   = '0;
      end
    end else if (bksp_p && n_entered != '0) begin
      nxt_cnt = n_entered - CNT_W'(1);
      for (int i = 0; i < NDIG; i++)
        if (i == int'(nxt_cnt)) nxt_word[WORD_W-1-i*DIGIT_W -: DIGIT_W] = '0;
    end else if (load_p && int'(n_entered) < NDIG) begin
      for (int i = 0; i < NDIG; i++)
        if (i == int'(n_entered)) nxt_word[WORD_W-1-i*DIGIT_W -: DIGIT_W] = dig;
      nxt_cnt   = n_entered + CNT_W'(1);
      nxt_state = int'(nxt_cnt) == NDIG ? OFFER : COLLECT;
    end
  end
  assign word_valid = state == OFFER;
  assign full       = int'(n_entered) == NDIG;
endmodule
